// File: rtl/cnn_weight_pkg.sv
// Shared state type and sizing/lane helpers for the ping-pong weight bank loader.
package cnn_weight_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2
    } ldr_state_t;

    function automatic int addr_width(input int depth_max);
        return $clog2(2 * depth_max);
    endfunction

    function automatic int depth_width(input int depth_max);
        return $clog2(depth_max + 1);
    endfunction

    // Row-major lane number of (row, col) in a tile whose edge is edge_len.
    function automatic int lane_idx(input int row, input int col, input int edge_len);
        return row * edge_len + col;
    endfunction

endpackage

// File: rtl/weight_tile_pad.sv
// Remaps a packed ksize x ksize slice into the fixed KERNEL_SIZE_MAX x KERNEL_SIZE_MAX lane layout.
// Remap is only built with WEIGHT_LOADER_ZERO_PAD_EN; otherwise data passes straight through.
module weight_tile_pad
    import cnn_weight_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int KERNEL_SIZE_MAX = 3
) (
    input  logic [3:0]                                           i_ksize,
    input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0] i_data,
    output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0] o_data
);

`ifdef WEIGHT_LOADER_ZERO_PAD_EN
    // Every (ksize, row, col) combination is unrolled so all lane selects are constant.
    always_comb begin
        o_data = '0;
        for (int ks = 1; ks <= KERNEL_SIZE_MAX; ks++) begin
            for (int row = 0; row < ks; row++) begin
                for (int col = 0; col < ks; col++) begin
                    if (int'(i_ksize) == ks) begin
                        o_data[lane_idx(row, col, KERNEL_SIZE_MAX)*DATA_WIDTH +: DATA_WIDTH] =
                            i_data[lane_idx(row, col, ks)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end
`else
    logic w_unused_ksize;
    assign w_unused_ksize = ^i_ksize;
    assign o_data         = i_data;
`endif

endmodule

// File: rtl/weight_bank_loader.sv
// Streams one kernel group into the shadow half of a ping-pong weight RAM and swaps halves on request.
// Optional lane remap/zero padding is enabled with WEIGHT_LOADER_ZERO_PAD_EN.
module weight_bank_loader
    import cnn_weight_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int KERNEL_SIZE_MAX = 3,
    parameter int PARA_KERNEL     = 2,
    parameter int DEPTH_MAX       = 64,
    parameter int AW              = addr_width(DEPTH_MAX),
    parameter int DW              = depth_width(DEPTH_MAX)
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 cfg_start,
    input  logic [DW-1:0]                                        cfg_depth,
    input  logic [3:0]                                           cfg_kernel_size,
    input  logic                                                 in_valid,
    output logic                                                 in_ready,
    input  logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0] in_data,
    output logic [PARA_KERNEL-1:0]                               wr_en,
    output logic [AW-1:0]                                        wr_addr,
    output logic [KERNEL_SIZE_MAX*KERNEL_SIZE_MAX*DATA_WIDTH-1:0] wr_data,
    output logic                                                 update_req,
    output logic [AW-1:0]                                        update_addr,
    input  logic                                                 swap_req,
    output logic                                                 swap_ack,
    output logic                                                 active_bank,
    output logic                                                 cfg_err,
    output logic                                                 busy
);

    localparam int BW = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX * DATA_WIDTH;
    localparam int KW = (PARA_KERNEL > 1) ? $clog2(PARA_KERNEL) : 1;

    ldr_state_t             r_state;
    ldr_state_t             w_state_nxt;
    logic [DW-1:0]          r_depth;
    logic [DW-1:0]          r_slice;
    logic [KW-1:0]          r_kern;
    logic [3:0]             r_ksize;
    logic                   r_bank;
    logic                   r_update_req;
    logic                   r_swap_ack;
    logic                   r_cfg_err;
    logic [PARA_KERNEL-1:0] r_wr_en;
    logic [AW-1:0]          r_wr_addr;
    logic [BW-1:0]          r_wr_data;
    logic [BW-1:0]          w_pad_data;
    logic [AW-1:0]          w_shadow_base;
    logic [AW-1:0]          w_wr_addr;
    logic                   w_cfg_ok;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_start;
    logic                   w_bad;
    logic                   w_swap;
    logic                   w_kern_wrap;

    assign w_cfg_ok = (cfg_depth != '0) && (cfg_depth <= DW'(DEPTH_MAX)) &&
                      (cfg_kernel_size != 4'd0) && (cfg_kernel_size <= 4'(KERNEL_SIZE_MAX));

    // in_ready is a pure state decode, so it never depends on in_valid.
    assign in_ready      = (r_state == ST_LOAD);
    assign w_accept      = in_valid && in_ready;
    assign w_kern_wrap   = (r_kern == KW'(PARA_KERNEL - 1));
    assign w_last        = (r_slice == r_depth - 1'b1) && w_kern_wrap;
    assign w_shadow_base = r_bank ? '0 : AW'(DEPTH_MAX);
    assign w_wr_addr     = w_shadow_base + AW'(r_slice);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_bad       = 1'b0;
        w_swap      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (w_cfg_ok) begin
                        w_state_nxt = ST_LOAD;
                        w_start     = 1'b1;
                    end else begin
                        w_bad = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_accept && w_last) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (swap_req) begin
                    w_state_nxt = ST_IDLE;
                    w_swap      = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth      <= '0;
            r_ksize      <= '0;
            r_slice      <= '0;
            r_kern       <= '0;
            r_bank       <= 1'b0;
            r_update_req <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_update_req <= (w_state_nxt == ST_IDLE);
            r_swap_ack   <= w_swap;
            if (w_bad) begin
                r_cfg_err <= 1'b1;
            end
            if (w_swap) begin
                r_bank <= ~r_bank;
            end
            // Slice-major order: walk all kernels of a slice before moving to the next slice.
            if (w_start) begin
                r_depth <= cfg_depth;
                r_ksize <= cfg_kernel_size;
                r_slice <= '0;
                r_kern  <= '0;
            end else if (w_accept) begin
                if (w_kern_wrap) begin
                    r_kern  <= '0;
                    r_slice <= r_slice + 1'b1;
                end else begin
                    r_kern <= r_kern + 1'b1;
                end
            end
        end
    end

    weight_tile_pad #(
        .DATA_WIDTH      (DATA_WIDTH),
        .KERNEL_SIZE_MAX (KERNEL_SIZE_MAX)
    ) u_pad (
        .i_ksize (r_ksize),
        .i_data  (in_data),
        .o_data  (w_pad_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= '0;
            if (w_accept) begin
                r_wr_en   <= PARA_KERNEL'(1) << r_kern;
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_pad_data;
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign update_req  = r_update_req;
    assign update_addr = r_update_req ? w_shadow_base : '0;
    assign swap_ack    = r_swap_ack;
    assign active_bank = r_bank;
    assign cfg_err     = r_cfg_err;
    assign busy        = (r_state != ST_IDLE);

endmodule
